instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, pc after reset.
REQ-004 SHALL have ports, one clock, synchronous active-low reset:
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  synchronous reset, active low
 rdy  in  1  global enable; low freezes all state
 instr_in_valid  in  1  instr_in holds word at instr_in_addr this cycle
 instr_in  in  32  instruction from icache
 instr_in_addr  out  32  fetch address (= pc)
 instr_predict_addr  out  32  predictor lookup address (= pc)
 jump  in  1  predictor taken for instr_predict_addr
 instr_out_valid  out  1  queue head valid
 instr_out_ready  in  1  consumer accepts head this cycle
 instr_out  out  32  head instruction
 instr_out_pc  out  32  head pc
 jumped  out  1  head was predicted/redirected taken
 flush  in  1  misprediction flush
 new_pc_enable  in  1  new_pc valid
 new_pc  in  32  resolved target

Function
REQ-005 SHALL hold state FETCH or STALL; enqueue only when rdy, FETCH, instr_in_valid, count<QUEUE_DEPTH, flush low.
REQ-006 SHALL compute next pc on enqueue: JAL (7'b1101111) pc+J-imm; branch (7'b1100011) pc+B-imm if jump else pc+4; JALR (7'b1100111) pc unchanged, go STALL; else pc+4; all 32-bit modulo 2^32.
REQ-007 SHALL record per entry jumped: branch=jump, JAL=1, JALR=0 (REQ-016 exception), others=0.
REQ-008 SHALL assert instr_out_valid iff count!=0; instr_out, instr_out_pc, jumped from head entry; enqueue-to-output latency one cycle.
REQ-009 SHALL dequeue when instr_out_valid and instr_out_ready; simultaneous enqueue and dequeue keeps count unchanged.
REQ-010 SHALL block enqueue when count==QUEUE_DEPTH even if dequeue occurs same cycle; pc held.
REQ-011 SHALL wrap head/tail pointers modulo QUEUE_DEPTH; count never exceeds QUEUE_DEPTH nor underflows.
REQ-012 SHALL in STALL, on new_pc_enable with flush low, set pc=new_pc and go FETCH next cycle; no enqueue in STALL.
REQ-013 SHALL on flush (highest priority, any state) empty queue, go FETCH, discard same-cycle enqueue/dequeue; pc=new_pc if new_pc_enable else pc unchanged.
REQ-014 SHALL ignore all inputs and hold all state while rdy low, reset excepted.

Reset
REQ-015 SHALL on rising clk with rst_n low: pc=RESET_PC, state FETCH, count=0, pointers=0, instr_out_valid=0, instr_out=0, instr_out_pc=0, jumped=0, RAS empty; reset dominates rdy and flush.

Configuration
REQ-016 SHALL with IFQ_RAS_EN defined include RAS: JAL/JALR with rd in {x1,x5} push pc+4; JALR rd=x0 rs1=x1 imm=0 with RAS non-empty pops top, pc=top, entry jumped=1, no STALL; push when full overwrites oldest (circular); push+pop same instruction pops then pushes; flush leaves RAS unchanged.
REQ-017 SHALL without IFQ_RAS_EN contain no RAS logic; every JALR enters STALL with jumped=0.

Verification
REQ-018 Reset: rst_n=0 one cycle, RESET_PC=32'h100 -> instr_in_addr=32'h100, instr_out_valid=0, count 0.
REQ-019 Fill: 5 ADDI words, ready=0, DEPTH=4 -> 4 enqueued pcs 0,4,8,C; pc stays 32'h10; then ready=1 -> drains in order, fifth enqueued after first dequeue.
REQ-020 Branch: pc=32'h20 BEQ imm=-8, jump=1 -> next instr_in_addr=32'h18, entry jumped=1; jump=0 -> 32'h24, jumped=0.
REQ-021 JALR: pc=32'h40 JALR x0,0(x5) -> STALL, no enqueue for 3 cycles; new_pc_enable new_pc=32'h200 -> instr_in_addr=32'h200, FETCH.
REQ-022 Flush: queue 3 entries, flush+new_pc_enable new_pc=32'h80 while enqueue pending -> next cycle instr_out_valid=0, instr_in_addr=32'h80.
REQ-023 RAS (IFQ_RAS_EN): JAL x1 at 32'h10 to 32'h100, RET at 32'h100 -> next pc 32'h14, jumped=1, no STALL; undefined -> STALL.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: static next-pc prediction, JALR stall and optional return-address stack.
// Define IFQ_RAS_EN to build the return-address stack (returns predicted without stalling).
module instr_fetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter int          RAS_DEPTH   = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        instr_in_valid,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_in_addr,
    output logic [31:0] instr_predict_addr,
    input  logic        jump,
    output logic        instr_out_valid,
    input  logic        instr_out_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_out_pc,
    output logic        jumped,
    input  logic        flush,
    input  logic        new_pc_enable,
    input  logic [31:0] new_pc
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam logic [QW:0] FULL = (QW+1)'(QUEUE_DEPTH);

    typedef enum logic {FETCH = 1'b0, STALL = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [QW-1:0] head_q, head_d, tail_q, tail_d;
    logic [QW:0]   count_q, count_d;
    logic [31:0] q_instr_q [QUEUE_DEPTH];
    logic [31:0] q_instr_d [QUEUE_DEPTH];
    logic [31:0] q_pc_q [QUEUE_DEPTH];
    logic [31:0] q_pc_d [QUEUE_DEPTH];
    logic        q_jmp_q [QUEUE_DEPTH];
    logic        q_jmp_d [QUEUE_DEPTH];

    logic        enq, deq;
    logic [31:0] nxt_pc, j_imm, b_imm;
    logic        nxt_stall, ent_jmp;
    logic        is_jal, is_br, is_jalr;

`ifdef IFQ_RAS_EN
    localparam int RW = $clog2(RAS_DEPTH);
    localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);
    logic [31:0]   ras_q [RAS_DEPTH];
    logic [31:0]   ras_d [RAS_DEPTH];
    logic [RW-1:0] ras_sp_q, ras_sp_d;
    logic [RW:0]   ras_cnt_q, ras_cnt_d;
    logic          ras_push, ras_pop;
    logic [31:0]   ras_top;

    // rd in {x1,x5} is a link register; jalr x0,0(x1) is a return
    assign ras_push = (is_jal || is_jalr) && (instr_in[11:7] == 5'd1 || instr_in[11:7] == 5'd5);
    assign ras_pop  = is_jalr && instr_in[11:7] == 5'd0 && instr_in[19:15] == 5'd1 &&
                      instr_in[31:20] == 12'd0 && ras_cnt_q != '0;
    assign ras_top  = ras_q[ras_sp_q - 1'b1];
`endif

    assign is_jal  = instr_in[6:0] == 7'b1101111;
    assign is_br   = instr_in[6:0] == 7'b1100011;
    assign is_jalr = instr_in[6:0] == 7'b1100111;
    assign j_imm   = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
    assign b_imm   = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};

    always_comb begin
        nxt_pc    = pc_q + 32'd4;
        nxt_stall = 1'b0;
        ent_jmp   = 1'b0;
        if (is_jal) begin
            nxt_pc  = pc_q + j_imm;
            ent_jmp = 1'b1;
        end else if (is_br) begin
            if (jump) begin
                nxt_pc  = pc_q + b_imm;
                ent_jmp = 1'b1;
            end
        end else if (is_jalr) begin
`ifdef IFQ_RAS_EN
            if (ras_pop) begin
                nxt_pc  = ras_top;
                ent_jmp = 1'b1;
            end else begin
                nxt_pc    = pc_q;
                nxt_stall = 1'b1;
            end
`else
            nxt_pc    = pc_q;
            nxt_stall = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        q_jmp_d   = q_jmp_q;
`ifdef IFQ_RAS_EN
        ras_d     = ras_q;
        ras_sp_d  = ras_sp_q;
        ras_cnt_d = ras_cnt_q;
`endif
        enq = 1'b0;
        deq = 1'b0;
        if (rdy) begin
            if (flush) begin
                // flush wins over everything; the stack is deliberately kept
                count_d = '0;
                head_d  = '0;
                tail_d  = '0;
                state_d = FETCH;
                if (new_pc_enable) pc_d = new_pc;
            end else begin
                enq = (state_q == FETCH) && instr_in_valid && (count_q != FULL);
                deq = instr_out_valid && instr_out_ready;
                if (enq) begin
                    q_instr_d[tail_q] = instr_in;
                    q_pc_d[tail_q]    = pc_q;
                    q_jmp_d[tail_q]   = ent_jmp;
                    tail_d            = tail_q + 1'b1;
                    pc_d              = nxt_pc;
                    state_d           = nxt_stall ? STALL : FETCH;
`ifdef IFQ_RAS_EN
                    if (ras_pop) begin
                        ras_sp_d  = ras_sp_q - 1'b1;
                        ras_cnt_d = ras_cnt_q - 1'b1;
                    end
                    if (ras_push) begin
                        ras_d[ras_sp_d] = pc_q + 32'd4;
                        ras_sp_d        = ras_sp_d + 1'b1;
                        if (ras_cnt_d != RAS_FULL) ras_cnt_d = ras_cnt_d + 1'b1;
                    end
`endif
                end
                if (deq) head_d = head_q + 1'b1;
                case ({enq, deq})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                if (state_q == STALL && new_pc_enable) begin
                    pc_d    = new_pc;
                    state_d = FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
`ifdef IFQ_RAS_EN
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            q_instr_q <= q_instr_d;
            q_pc_q    <= q_pc_d;
            q_jmp_q   <= q_jmp_d;
`ifdef IFQ_RAS_EN
            ras_q     <= ras_d;
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
`endif
        end
    end

    assign instr_in_addr      = pc_q;
    assign instr_predict_addr = pc_q;
    assign instr_out_valid    = count_q != '0;
    assign instr_out          = instr_out_valid ? q_instr_q[head_q] : 32'd0;
    assign instr_out_pc       = instr_out_valid ? q_pc_q[head_q] : 32'd0;
    assign jumped             = instr_out_valid ? q_jmp_q[head_q] : 1'b0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected head entries queued at enqueue, checked at dequeue.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n, rdy, instr_in_valid, jump, instr_out_ready, flush, new_pc_enable;
    logic [31:0] instr_in, new_pc;
    logic [31:0] instr_in_addr, instr_predict_addr, instr_out, instr_out_pc;
    logic        instr_out_valid, jumped;

    always #5 clk = ~clk;

    instr_fetch_queue #(.QUEUE_DEPTH(4), .RAS_DEPTH(4), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .instr_in_valid(instr_in_valid), .instr_in(instr_in),
        .instr_in_addr(instr_in_addr), .instr_predict_addr(instr_predict_addr),
        .jump(jump), .instr_out_valid(instr_out_valid), .instr_out_ready(instr_out_ready),
        .instr_out(instr_out), .instr_out_pc(instr_out_pc), .jumped(jumped),
        .flush(flush), .new_pc_enable(new_pc_enable), .new_pc(new_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jmp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] BEQ_M8  = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] JALR_X5 = 32'h00028067; // jalr x0,0(x5)
    localparam logic [31:0] RET     = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] JAL_X1  = 32'h0F0000EF; // jal x1,+0xF0

    function automatic logic [31:0] addi(input int i);
        return (32'(i) << 20) | 32'h00000093;
    endfunction

    // A dequeue happens on the coming edge; compare the head against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rdy && !flush && instr_out_valid && instr_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL deq_unexpected: got instr=%h pc=%h, none expected", instr_out, instr_out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr_out !== e.instr || instr_out_pc !== e.pc || jumped !== e.jmp) begin
                    errors++;
                    $display("FAIL deq_entry: got instr=%h pc=%h jumped=%b want instr=%h pc=%h jumped=%b",
                             instr_out, instr_out_pc, jumped, e.instr, e.pc, e.jmp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic j);
        exp_t e;
        e.instr = i; e.pc = p; e.jmp = j;
        sb.push_back(e);
    endtask

    task automatic do_flush(input logic [31:0] p, input logic en);
        flush = 1'b1; new_pc_enable = en; new_pc = p;
        step();
        flush = 1'b0; new_pc_enable = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        instr_in_valid = 1'b0;
        instr_out_ready = 1'b1;
        for (int k = 0; k < 20 && instr_out_valid; k++) step();
        checks++;
        if (instr_out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got valid=%b left=%0d want valid=0 left=0", name, instr_out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b1; new_pc_enable = 1'b1; new_pc = 32'hDEAD;
        instr_in_valid = 1'b1; instr_in = NOP; jump = 1'b0; instr_out_ready = 1'b0;
        step();
        rst_n = 1'b1; flush = 1'b0; new_pc_enable = 1'b0; instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want 00000100", instr_in_addr); end
        checks++; if (instr_predict_addr !== 32'h100) begin errors++; $display("FAIL reset_pred: got %h want 00000100", instr_predict_addr); end
        checks++; if (instr_out_valid !== 1'b0 || instr_out !== 32'h0 || instr_out_pc !== 32'h0 || jumped !== 1'b0) begin
            errors++; $display("FAIL reset_out: got v=%b i=%h p=%h j=%b want all zero", instr_out_valid, instr_out, instr_out_pc, jumped);
        end
        step();
        checks++; if (instr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got valid=%b want 0", instr_out_valid); end
    endtask

    task automatic test_rdy_hold();
        instr_out_ready = 1'b0; instr_in = NOP; instr_in_valid = 1'b1;
        push(NOP, 32'h100, 1'b0);
        step();
        rdy = 1'b0; flush = 1'b1; new_pc_enable = 1'b1; new_pc = 32'h999; instr_out_ready = 1'b1;
        step(); step();
        checks++; if (instr_in_addr !== 32'h104 || instr_out_valid !== 1'b1 || instr_out_pc !== 32'h100) begin
            errors++; $display("FAIL rdy_hold: got pc=%h v=%b hp=%h want pc=00000104 v=1 hp=00000100", instr_in_addr, instr_out_valid, instr_out_pc);
        end
        rdy = 1'b1; flush = 1'b0; new_pc_enable = 1'b0;
        drain("rdy_hold");
    endtask

    task automatic test_fill();
        do_flush(32'h0, 1'b1);
        instr_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr_in = addi(i); instr_in_valid = 1'b1;
            if (i < 4) push(addi(i), 32'(i * 4), 1'b0);
            step();
        end
        checks++; if (instr_in_addr !== 32'h10 || instr_out !== addi(0) || instr_out_pc !== 32'h0) begin
            errors++; $display("FAIL fill_full: got pc=%h head=%h hp=%h want pc=00000010 head=%h hp=0", instr_in_addr, instr_out, instr_out_pc, addi(0));
        end
        step();
        checks++; if (instr_in_addr !== 32'h10) begin errors++; $display("FAIL fill_hold: got %h want 00000010", instr_in_addr); end
        push(addi(4), 32'h10, 1'b0);
        instr_out_ready = 1'b1;
        step();
        checks++; if (instr_in_addr !== 32'h10) begin errors++; $display("FAIL fill_deq_block: got %h want 00000010", instr_in_addr); end
        step();
        instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h14) begin errors++; $display("FAIL fill_fifth: got %h want 00000014", instr_in_addr); end
        drain("fill");
    endtask

    task automatic test_branch();
        do_flush(32'h20, 1'b1);
        instr_out_ready = 1'b1; instr_in = BEQ_M8; jump = 1'b1; instr_in_valid = 1'b1;
        push(BEQ_M8, 32'h20, 1'b1);
        step();
        instr_in_valid = 1'b0; jump = 1'b0;
        checks++; if (instr_in_addr !== 32'h18 || jumped !== 1'b1) begin
            errors++; $display("FAIL br_taken: got pc=%h jumped=%b want pc=00000018 jumped=1", instr_in_addr, jumped);
        end
        drain("br_taken");
        do_flush(32'h20, 1'b1);
        instr_in = BEQ_M8; jump = 1'b0; instr_in_valid = 1'b1;
        push(BEQ_M8, 32'h20, 1'b0);
        step();
        instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h24 || jumped !== 1'b0) begin
            errors++; $display("FAIL br_not_taken: got pc=%h jumped=%b want pc=00000024 jumped=0", instr_in_addr, jumped);
        end
        drain("br_nt");
    endtask

    task automatic test_jal_ret();
        do_flush(32'h10, 1'b1);
        instr_out_ready = 1'b1; instr_in = JAL_X1; instr_in_valid = 1'b1;
        push(JAL_X1, 32'h10, 1'b1);
        step();
        checks++; if (instr_in_addr !== 32'h100) begin errors++; $display("FAIL jal_target: got %h want 00000100", instr_in_addr); end
        instr_in = RET;
`ifdef IFQ_RAS_EN
        push(RET, 32'h100, 1'b1);
        step();
        checks++; if (instr_in_addr !== 32'h14) begin errors++; $display("FAIL ret_pop: got %h want 00000014", instr_in_addr); end
        push(RET, 32'h14, 1'b0);
        step();
        instr_in = NOP;
        step();
        checks++; if (instr_in_addr !== 32'h14) begin errors++; $display("FAIL ret_empty_stall: got %h want 00000014", instr_in_addr); end
`else
        push(RET, 32'h100, 1'b0);
        step();
        instr_in = NOP;
        step();
        checks++; if (instr_in_addr !== 32'h100) begin errors++; $display("FAIL ret_stall: got %h want 00000100", instr_in_addr); end
`endif
        drain("jal_ret");
    endtask

    task automatic test_jalr();
        do_flush(32'h40, 1'b1);
        instr_out_ready = 1'b1; instr_in = JALR_X5; instr_in_valid = 1'b1;
        push(JALR_X5, 32'h40, 1'b0);
        step();
        instr_in = NOP;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (instr_in_addr !== 32'h40) begin errors++; $display("FAIL jalr_stall%0d: got %h want 00000040", k, instr_in_addr); end
        end
        instr_in_valid = 1'b0; new_pc_enable = 1'b1; new_pc = 32'h200;
        step();
        new_pc_enable = 1'b0;
        checks++; if (instr_in_addr !== 32'h200) begin errors++; $display("FAIL jalr_resume: got %h want 00000200", instr_in_addr); end
        instr_in_valid = 1'b1;
        push(NOP, 32'h200, 1'b0);
        step();
        instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h204) begin errors++; $display("FAIL jalr_fetch: got %h want 00000204", instr_in_addr); end
        drain("jalr");
    endtask

    task automatic test_flush();
        do_flush(32'h60, 1'b1);
        instr_out_ready = 1'b0; instr_in = NOP; instr_in_valid = 1'b1;
        step(); step(); step();
        checks++; if (instr_in_addr !== 32'h6C || instr_out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_prefill: got pc=%h v=%b want pc=0000006c v=1", instr_in_addr, instr_out_valid);
        end
        instr_out_ready = 1'b1;
        do_flush(32'h80, 1'b1);
        checks++; if (instr_out_valid !== 1'b0 || instr_in_addr !== 32'h80) begin
            errors++; $display("FAIL flush_empty: got v=%b pc=%h want v=0 pc=00000080", instr_out_valid, instr_in_addr);
        end
        do_flush(32'h555, 1'b0);
        checks++; if (instr_in_addr !== 32'h80) begin errors++; $display("FAIL flush_keep_pc: got %h want 00000080", instr_in_addr); end
        push(NOP, 32'h80, 1'b0);
        step();
        instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h84 || instr_out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_refill: got pc=%h v=%b want pc=00000084 v=1", instr_in_addr, instr_out_valid);
        end
        drain("flush");
    endtask

    task automatic test_back_to_back();
        do_flush(32'h300, 1'b1);
        instr_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_in = addi(i + 16); instr_in_valid = 1'b1;
            push(addi(i + 16), 32'h300 + 32'(4 * i), 1'b0);
            step();
        end
        instr_in_valid = 1'b0;
        checks++; if (instr_in_addr !== 32'h328) begin errors++; $display("FAIL b2b_pc: got %h want 00000328", instr_in_addr); end
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_rdy_hold();
        test_fill();
        test_branch();
        test_jal_ret();
        test_jalr();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
